// File: rtl/chess_pkg.sv
// Shared definitions for the board scorer: piece codes, material values,
// slave register indices and the scorer FSM state encoding.
package chess_pkg;

   // Piece codes are signed bytes: white positive, black negative.
   localparam logic signed [7:0] EMPTY    = 8'sd0;
   localparam logic signed [7:0] WPAWN0   = 8'sd1;
   localparam logic signed [7:0] WPAWN7   = 8'sd8;
   localparam logic signed [7:0] WROOK0   = 8'sd9;
   localparam logic signed [7:0] WROOK9   = 8'sd18;
   localparam logic signed [7:0] WKNIGHT0 = 8'sd19;
   localparam logic signed [7:0] WKNIGHT9 = 8'sd28;
   localparam logic signed [7:0] WBISHOP0 = 8'sd29;
   localparam logic signed [7:0] WBISHOP9 = 8'sd38;
   localparam logic signed [7:0] WQUEEN0  = 8'sd39;
   localparam logic signed [7:0] WQUEEN8  = 8'sd47;
   localparam logic signed [7:0] WKING    = 8'sd48;
   localparam logic signed [7:0] BPAWN0   = -8'sd1;
   localparam logic signed [7:0] BKING    = -8'sd48;

   // Material values in pawn units (magnitude; sign follows the piece colour).
   localparam logic signed [4:0] VAL_NONE   = 5'sd0;
   localparam logic signed [4:0] VAL_PAWN   = 5'sd1;
   localparam logic signed [4:0] VAL_KNIGHT = 5'sd3;
   localparam logic signed [4:0] VAL_BISHOP = 5'sd3;
   localparam logic signed [4:0] VAL_ROOK   = 5'sd5;
   localparam logic signed [4:0] VAL_QUEEN  = 5'sd9;

   // Slave register indices.
   localparam logic [3:0] REG_CTRL  = 4'd0;
   localparam logic [3:0] REG_BASE  = 4'd1;
   localparam logic [3:0] REG_COUNT = 4'd2;
   localparam logic [3:0] REG_SIDE  = 4'd3;
   localparam logic [3:0] REG_SCORE = 4'd4;
   localparam logic [3:0] REG_INDEX = 4'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_REQ,
      ST_WAIT,
      ST_ACC,
      ST_CMP,
      ST_DONE
   } state_t;

endpackage

// File: rtl/piece_value.sv
// Combinational piece-code to material-value lookup. Works on the code
// magnitude and re-applies the colour sign, so black pieces score negative.
module piece_value
   import chess_pkg::*;
(
   input  logic signed [7:0] code,
   output logic signed [4:0] value
);

   logic        [7:0] mag;
   logic signed [4:0] mag_val;

   // Magnitude lookup; -128 folds to 128, which lands in the "unknown" range.
   always_comb begin
      mag     = code[7] ? 8'(-code) : 8'(code);
      mag_val = VAL_NONE;
      if (mag >= $unsigned(WPAWN0) && mag <= $unsigned(WPAWN7))
         mag_val = VAL_PAWN;
      else if (mag >= $unsigned(WROOK0) && mag <= $unsigned(WROOK9))
         mag_val = VAL_ROOK;
      else if (mag >= $unsigned(WKNIGHT0) && mag <= $unsigned(WKNIGHT9))
         mag_val = VAL_KNIGHT;
      else if (mag >= $unsigned(WBISHOP0) && mag <= $unsigned(WBISHOP9))
         mag_val = VAL_BISHOP;
      else if (mag >= $unsigned(WQUEEN0) && mag <= $unsigned(WQUEEN8))
         mag_val = VAL_QUEEN;
      value = code[7] ? -mag_val : mag_val;
   end

endmodule

// File: rtl/board_scorer.sv
// Board scorer: walks N boards of 64 signed piece bytes in SDRAM one square
// per read, sums material per board and tracks the best board for the side
// to move. Configured and started through a small Avalon slave.
module board_scorer
   import chess_pkg::*;
#(
   parameter int MAX_BOARDS = 64
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        slave_waitrequest,
   input  logic [3:0]  slave_address,
   input  logic        slave_read,
   output logic [31:0] slave_readdata,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   input  logic        master_waitrequest,
   output logic [31:0] master_address,
   output logic        master_read,
   input  logic [31:0] master_readdata,
   input  logic        master_readdatavalid
);

   localparam int CNT_W = $clog2(MAX_BOARDS + 1);
   localparam int IDX_W = (MAX_BOARDS > 1) ? $clog2(MAX_BOARDS) : 1;

   state_t                   state, state_nxt;
   logic        [31:0]       base_addr;
   logic        [CNT_W-1:0]  board_cnt;
   logic        [CNT_W-1:0]  board;
   logic        [5:0]        square;
   logic                     side;
   logic signed [15:0]       acc;
   logic signed [15:0]       best_score;
   logic                     best_valid;
   logic        [IDX_W-1:0]  best_idx;
   logic signed [7:0]        code_q;
   logic signed [4:0]        code_val;
   logic                     start_req;
   logic                     data_in;
   logic                     last_board;
   logic                     better;
   logic                     unused_bits;

   assign unused_bits = ^{master_readdata[31:8], slave_writedata[31:1]};

   piece_value u_piece_value (
      .code  (code_q),
      .value (code_val)
   );

   assign start_req  = slave_write && (slave_address == REG_CTRL);
   // A read completes either in the cycle the request is accepted or later in WAIT.
   assign data_in    = master_readdatavalid &&
                       ((state == ST_WAIT) || (state == ST_REQ && !master_waitrequest));
   assign last_board = ((board + CNT_W'(1)) == board_cnt);
   // Board 0 is always taken; later boards must be strictly better.
   assign better     = !best_valid || (side ? (acc > best_score) : (acc < best_score));

   assign master_read    = (state == ST_REQ);
   assign master_address = base_addr + {{(26 - CNT_W){1'b0}}, board, 6'b0}
                                     + {26'b0, square};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic for the board walk.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_req) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = (board_cnt == '0) ? ST_DONE : ST_REQ;
         ST_REQ:  if (!master_waitrequest)
                     state_nxt = master_readdatavalid ? ST_ACC : ST_WAIT;
         ST_WAIT: if (master_readdatavalid) state_nxt = ST_ACC;
         ST_ACC:  state_nxt = (square == 6'd63) ? ST_CMP : ST_REQ;
         ST_CMP:  state_nxt = last_board ? ST_DONE : ST_REQ;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Configuration, counters and best-board tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_addr  <= '0;
         board_cnt  <= '0;
         side       <= 1'b0;
         board      <= '0;
         square     <= '0;
         best_score <= '0;
         best_valid <= 1'b0;
         best_idx   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (slave_write) begin
               case (slave_address)
                  REG_BASE:  base_addr <= slave_writedata;
                  REG_COUNT: board_cnt <= (slave_writedata > 32'(MAX_BOARDS))
                                          ? CNT_W'(MAX_BOARDS)
                                          : slave_writedata[CNT_W-1:0];
                  REG_SIDE:  side      <= slave_writedata[0];
                  default: ;
               endcase
            end
            ST_LOAD: begin
               board      <= '0;
               square     <= '0;
               best_score <= '0;
               best_valid <= 1'b0;
            end
            ST_ACC:  square <= square + 6'd1;
            ST_CMP: begin
               if (better) begin
                  best_score <= acc;
                  best_valid <= 1'b1;
                  best_idx   <= board[IDX_W-1:0];
               end
               board <= board + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Read-data capture and per-board material accumulation.
   always_ff @(posedge clk) begin
      if (data_in) code_q <= $signed(master_readdata[7:0]);
      case (state)
         ST_LOAD: acc <= '0;
         ST_ACC:  acc <= acc + $signed({{11{code_val[4]}}, code_val});
         ST_CMP:  acc <= '0;
         default: ;
      endcase
   end

   // Slave read mux; status reads stall while a scoring run is in progress.
   always_comb begin
      slave_waitrequest = slave_read && (slave_address == REG_CTRL) && (state != ST_IDLE);
      slave_readdata    = '0;
      if (slave_read) begin
         case (slave_address)
            REG_CTRL:  slave_readdata = 32'd1;
            REG_SCORE: slave_readdata = {{16{best_score[15]}}, best_score};
            REG_INDEX: slave_readdata = best_valid ? 32'(best_idx) : 32'hFFFF_FFFF;
            default:   slave_readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_board_scorer.sv
// Directed bench for board_scorer with an SDRAM responder model that can
// insert waitrequest and read-latency delays.
module tb_board_scorer;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          LIMIT = 20000;

   logic        clk, rst;
   logic        slave_waitrequest, slave_read, slave_write;
   logic [3:0]  slave_address;
   logic [31:0] slave_readdata, slave_writedata;
   logic        master_waitrequest, master_read, master_readdatavalid;
   logic [31:0] master_address, master_readdata;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [0:4095];
   int   reads, rd_pulses, addr_err, bad_addr;
   bit   rand_mode;
   int   wr_cnt, lat_cnt;
   bit   pend, held;
   logic [7:0]  pend_data;
   logic [31:0] held_addr;

   board_scorer dut (
      .clk                  (clk),
      .rst                  (rst),
      .slave_waitrequest    (slave_waitrequest),
      .slave_address        (slave_address),
      .slave_read           (slave_read),
      .slave_readdata       (slave_readdata),
      .slave_write          (slave_write),
      .slave_writedata      (slave_writedata),
      .master_waitrequest   (master_waitrequest),
      .master_address       (master_address),
      .master_read          (master_read),
      .master_readdata      (master_readdata),
      .master_readdatavalid (master_readdatavalid)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // SDRAM responder: decides waitrequest/readdatavalid each cycle at the negedge.
   initial begin
      logic [31:0] idx;
      logic [7:0]  data;
      int lat;
      master_waitrequest = 0; master_readdatavalid = 0; master_readdata = 0;
      reads = 0; rd_pulses = 0; addr_err = 0; bad_addr = 0;
      wr_cnt = 0; lat_cnt = 0; pend = 0; held = 0; held_addr = 0; pend_data = 0;
      forever begin
         @(negedge clk);
         master_readdatavalid = 0;
         if (held && master_read && master_address !== held_addr) addr_err++;
         if (pend) begin
            if (lat_cnt == 0) begin
               master_readdatavalid = 1;
               master_readdata = {24'hA5A5A5, pend_data};
               pend = 0;
            end else lat_cnt--;
         end
         master_waitrequest = 0;
         if (master_read) begin
            rd_pulses++;
            if (wr_cnt > 0) begin
               master_waitrequest = 1;
               wr_cnt--;
            end else begin
               reads++;
               idx = master_address - BASE;
               if (idx < 32'd4096) data = mem[idx[11:0]];
               else begin data = 8'h00; bad_addr++; end
               lat    = rand_mode ? int'($urandom_range(0, 5)) : 0;
               wr_cnt = rand_mode ? int'($urandom_range(0, 5)) : 0;
               if (lat == 0) begin
                  master_readdatavalid = 1;
                  master_readdata = {24'hA5A5A5, data};
               end else begin
                  pend = 1; lat_cnt = lat - 1; pend_data = data;
               end
            end
         end
         held      = master_read && master_waitrequest;
         held_addr = master_address;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
   endtask

   task automatic set_sq(input int b, input int sq, input logic [7:0] code);
      mem[b*64 + sq] = code;
   endtask

   task automatic kings(input int b);
      set_sq(b, 4, 8'd48);
      set_sq(b, 60, 8'hD0);   // -48
   endtask

   // Both slave tasks are entered and left 1 time unit after a rising edge.
   task automatic sw(input logic [3:0] a, input logic [31:0] d);
      slave_address = a; slave_writedata = d; slave_write = 1;
      @(posedge clk); #1;
      slave_write = 0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d, output int waits, output bit to);
      slave_address = a; slave_read = 1; waits = 0; to = 0; d = 0;
      forever begin
         @(negedge clk);
         if (!slave_waitrequest) begin d = slave_readdata; break; end
         waits++;
         if (waits > LIMIT) begin to = 1; break; end
      end
      @(posedge clk); #1;
      slave_read = 0;
   endtask

   task automatic run_board(input string name, input int cnt, input int sd,
                            input logic [31:0] exp_score, input logic [31:0] exp_idx,
                            input int exp_reads, input int exp_waits, input bit busy);
      logic [31:0] d;
      int w;
      bit to;
      sw(4'd1, BASE); sw(4'd2, cnt); sw(4'd3, sd);
      reads = 0; rd_pulses = 0; bad_addr = 0; addr_err = 0;
      sw(4'd0, 32'd1);
      if (busy) begin
         slave_address = 4'd2; slave_writedata = 32'd3; slave_write = 1;
         @(negedge clk);
         checks++;
         if (slave_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_write_wait got=%b want=0", name, slave_waitrequest);
         end
         @(posedge clk); #1;
         slave_write = 0;
         sw(4'd1, BASE + 32'd64);
         sw(4'd3, (sd == 0) ? 32'd1 : 32'd0);
         sw(4'd0, 32'd1);
      end
      rd(4'd0, d, w, to);
      checks++;
      if (to || d !== 32'd1) begin
         failures++;
         $display("FAIL %s status got=%h timeout=%0d want=00000001", name, d, to);
      end
      if (exp_waits >= 0) begin
         checks++;
         if (w !== exp_waits) begin
            failures++;
            $display("FAIL %s status_waits got=%0d want=%0d", name, w, exp_waits);
         end
      end
      rd(4'd4, d, w, to);
      checks++;
      if (d !== exp_score) begin
         failures++;
         $display("FAIL %s score got=%h want=%h", name, d, exp_score);
      end
      rd(4'd5, d, w, to);
      checks++;
      if (d !== exp_idx) begin
         failures++;
         $display("FAIL %s index got=%h want=%h", name, d, exp_idx);
      end
      checks++;
      if (reads !== exp_reads) begin
         failures++;
         $display("FAIL %s reads got=%0d want=%0d", name, reads, exp_reads);
      end
      checks++;
      if (bad_addr !== 0 || addr_err !== 0) begin
         failures++;
         $display("FAIL %s address bad=%0d unstable=%0d want=0/0", name, bad_addr, addr_err);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int w;
      bit to;
      rst = 1; slave_read = 0; slave_write = 0; slave_address = 0; slave_writedata = 0;
      rand_mode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (master_read !== 1'b0 || master_address !== 32'd0 ||
          slave_waitrequest !== 1'b0 || slave_readdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs got rd=%b addr=%h swait=%b rdata=%h want 0/0/0/0",
                  master_read, master_address, slave_waitrequest, slave_readdata);
      end
      rst = 0;
      @(posedge clk); #1;
      rd(4'd4, d, w, to);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL reset_score got=%h want=0", d); end
      rd(4'd5, d, w, to);
      checks++;
      if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_index got=%h want=ffffffff", d); end
      rd(4'd0, d, w, to);
      checks++;
      if (d !== 32'd1 || w !== 0) begin
         failures++;
         $display("FAIL reset_status got=%h waits=%0d want=1/0", d, w);
      end
      rd(4'd9, d, w, to);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL unmapped_read got=%h want=0", d); end
   endtask

   task automatic test_single();
      clear_mem(); kings(0);
      run_board("single", 1, 1, 32'd0, 32'd0, 64, 131, 0);
   endtask

   task automatic test_white_max(input bit rnd);
      rand_mode = rnd;
      clear_mem();
      kings(0); set_sq(0, 12, 8'd3);    // +1
      kings(1); set_sq(1, 3, 8'd39);    // +9
      run_board(rnd ? "white_rand" : "white", 2, 1, 32'd9, 32'd1, 128, rnd ? -1 : 260, 0);
      rand_mode = 0;
   endtask

   task automatic test_black_tie(input bit rnd);
      rand_mode = rnd;
      clear_mem();
      // board 0: -3 +3 -3 = -3 (100 and -128 are unknown codes)
      kings(0); set_sq(0, 10, 8'hED); set_sq(0, 20, 8'd29); set_sq(0, 30, 8'hE2);
      set_sq(0, 40, 8'd100); set_sq(0, 41, 8'h80);
      // board 1: -5 -5 +5 = -5
      kings(1); set_sq(1, 0, 8'hF7); set_sq(1, 7, 8'hEE); set_sq(1, 63, 8'd12);
      // board 2: -5, +-49 are unknown
      kings(2); set_sq(2, 33, 8'hF1); set_sq(2, 34, 8'hCF); set_sq(2, 35, 8'd49);
      run_board(rnd ? "black_rand" : "black", 3, 0, 32'hFFFF_FFFB, 32'd1, 192, rnd ? -1 : 389, 0);
      rand_mode = 0;
   endtask

   task automatic test_count_zero();
      logic [31:0] d;
      int w;
      bit to;
      sw(4'd2, 32'd0);
      rd_pulses = 0;
      sw(4'd0, 32'd1);
      rd(4'd0, d, w, to);
      checks++;
      if (to || d !== 32'd1 || w + 1 > 3) begin
         failures++;
         $display("FAIL count0_status got=%h waits=%0d want=1 within 3 cycles", d, w);
      end
      rd(4'd5, d, w, to);
      checks++;
      if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count0_index got=%h want=ffffffff", d); end
      rd(4'd4, d, w, to);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL count0_score got=%h want=0", d); end
      checks++;
      if (rd_pulses !== 0) begin failures++; $display("FAIL count0_reads got=%0d want=0", rd_pulses); end
   endtask

   task automatic test_busy_writes();
      clear_mem(); kings(0);
      kings(1); set_sq(1, 5, 8'd40);     // only reachable if base moved
      run_board("busy", 1, 1, 32'd0, 32'd0, 64, -1, 1);
   endtask

   task automatic test_clamp();
      clear_mem();
      set_sq(5, 17, 8'd41);              // +9 on board 5
      set_sq(9, 2, 8'd1);                // +1 on board 9
      run_board("clamp", 100, 1, 32'd9, 32'd5, 4096, 8258, 0);
   endtask

   task automatic test_rst_mid();
      int n;
      clear_mem(); kings(0); kings(1); set_sq(1, 6, 8'd20);
      rand_mode = 1;
      sw(4'd1, BASE); sw(4'd2, 32'd2); sw(4'd3, 32'd1); sw(4'd0, 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(master_read && master_address >= BASE + 32'd74) && n < LIMIT);
      checks++;
      if (n >= LIMIT) begin failures++; $display("FAIL rst_mid_reach got=timeout want=board1"); end
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (master_read !== 1'b0) begin failures++; $display("FAIL rst_mid_read got=%b want=0", master_read); end
      rst = 0;
      repeat (12) @(posedge clk);
      #1;
      begin
         logic [31:0] d;
         int w;
         bit to;
         rd(4'd5, d, w, to);
         checks++;
         if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_mid_index got=%h want=ffffffff", d); end
      end
      clear_mem(); kings(0);
      run_board("after_rst", 1, 1, 32'd0, 32'd0, 64, -1, 0);
      rand_mode = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_white_max(0);
      test_black_tie(0);
      test_count_zero();
      test_busy_writes();
      test_clamp();
      test_white_max(1);
      test_black_tie(1);
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
